// File: rtl/axi_rd_pkg.sv
// Shared types for the AXI read-port arbiter: burst encodings, FSM states
// and the latched AR request.
package axi_rd_pkg;

  // Width of the address carried in ar_req_t; the arbiter's ADDR_WIDTH defaults to it.
  localparam int AR_ADDR_W = 32;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_e;

  typedef struct packed {
    logic [AR_ADDR_W-1:0] addr;
    logic [3:0]           len;
    burst_e               burst;
  } ar_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright; on a tie the
// port that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // One-hot grant selection
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_grant)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read master between the I-cache (port 0) and D-cache (port 1)
// refill engines: one burst in flight, round-robin grant, beat-count checking.
module axi_rd_arbiter
  import axi_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = AR_ADDR_W,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            s_arvalid,
  input  logic [ADDR_WIDTH-1:0] s_araddr0,
  input  logic [ADDR_WIDTH-1:0] s_araddr1,
  input  logic [3:0]            s_arlen0,
  input  logic [3:0]            s_arlen1,
  input  logic [1:0]            s_arburst0,
  input  logic [1:0]            s_arburst1,
  output logic [1:0]            s_arready,
  output logic [1:0]            s_rvalid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_rlast,
  input  logic [1:0]            s_rready,
  output logic                  m_arvalid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [3:0]            m_arlen,
  output logic [1:0]            m_arburst,
  output logic [ID_WIDTH-1:0]   m_arid,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rlast,
  input  logic [ID_WIDTH-1:0]   m_rid,
  input  logic [1:0]            m_rresp,
  output logic                  m_rready,
  output logic                  busy,
  output logic                  err
);

  state_e              state_q, state_d;
  ar_req_t             req_q, req_d;
  logic [ID_WIDTH-1:0] arid_q, arid_d;
  logic                last_grant_q, last_grant_d;
  logic [4:0]          beat_cnt_q, beat_cnt_d;
  logic                err_q, err_d;

  logic [1:0]          gnt_s;
  logic                gsel_s;
  logic                beat_acc_s;
  logic                beat_bad_s;

  rr_arb2 u_rr_arb2 (
    .req        (s_arvalid),
    .last_grant (last_grant_q),
    .gnt        (gnt_s)
  );

  assign gsel_s = last_grant_q;

  // State register and latched request (synchronous active-low reset)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      arid_q       <= '0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= 5'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      arid_q       <= arid_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
    end
  end

  // Beat protocol check: length/last agreement, ID echo and response status
  always_comb begin
    beat_bad_s = 1'b0;
    if (m_rlast && (beat_cnt_q != {1'b0, req_q.len})) begin
      beat_bad_s = 1'b1;
    end else if (!m_rlast && (beat_cnt_q == {1'b0, req_q.len})) begin
      beat_bad_s = 1'b1;
    end else if (m_rid != arid_q) begin
      beat_bad_s = 1'b1;
    end else if (m_rresp != 2'd0) begin
      beat_bad_s = 1'b1;
    end else begin
      beat_bad_s = 1'b0;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    arid_d       = arid_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    s_arready    = 2'b00;
    s_rvalid     = 2'b00;
    m_rready     = 1'b0;
    m_arvalid    = 1'b0;
    beat_acc_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_s != 2'b00) begin
          s_arready    = gnt_s;
          last_grant_d = gnt_s[1];
          beat_cnt_d   = 5'd0;
          arid_d       = '0;
          arid_d[0]    = gnt_s[1];
          state_d      = ST_AR;
          if (gnt_s[1]) begin
            req_d.addr  = AR_ADDR_W'(s_araddr1);
            req_d.len   = s_arlen1;
            req_d.burst = burst_e'(s_arburst1);
          end else begin
            req_d.addr  = AR_ADDR_W'(s_araddr0);
            req_d.len   = s_arlen0;
            req_d.burst = burst_e'(s_arburst0);
          end
        end else begin
          state_d = ST_IDLE;
        end
        // Any R beat outside a granted burst is a slave protocol violation
        if (m_rvalid) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      ST_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          state_d = ST_R;
        end else begin
          state_d = ST_AR;
        end
        if (m_rvalid) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      ST_R: begin
        s_rvalid[gsel_s] = m_rvalid;
        m_rready         = s_rready[gsel_s];
        beat_acc_s       = m_rvalid && s_rready[gsel_s];
        if (beat_acc_s) begin
          beat_cnt_d = beat_cnt_q + 5'd1;
          if (beat_bad_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          // Only m_rlast ends the burst, even when the count disagrees
          if (m_rlast) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_R;
          end
        end else begin
          state_d = ST_R;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Keep requesters from seeing a handshake while reset is applied
    if (!rst_n) begin
      s_arready = 2'b00;
      s_rvalid  = 2'b00;
      m_rready  = 1'b0;
      m_arvalid = 1'b0;
    end else begin
      m_arvalid = m_arvalid;
    end
  end

  assign s_rdata   = (state_q == ST_R) ? m_rdata : '0;
  assign s_rlast   = (state_q == ST_R) ? m_rlast : 1'b0;
  assign m_araddr  = ADDR_WIDTH'(req_q.addr);
  assign m_arlen   = req_q.len;
  assign m_arburst = req_q.burst;
  assign m_arid    = arid_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: the bench plays both cache requesters
// and the memory-side slave, checking every handshake against fixed values.
module tb_axi_rd_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  s_arvalid;
  logic [31:0] s_araddr0, s_araddr1;
  logic [3:0]  s_arlen0, s_arlen1;
  logic [1:0]  s_arburst0, s_arburst1;
  logic [1:0]  s_arready;
  logic [1:0]  s_rvalid;
  logic [63:0] s_rdata;
  logic        s_rlast;
  logic [1:0]  s_rready;
  logic        m_arvalid;
  logic [31:0] m_araddr;
  logic [3:0]  m_arlen;
  logic [1:0]  m_arburst;
  logic [3:0]  m_arid;
  logic        m_arready;
  logic        m_rvalid;
  logic [63:0] m_rdata;
  logic        m_rlast;
  logic [3:0]  m_rid;
  logic [1:0]  m_rresp;
  logic        m_rready;
  logic        busy;
  logic        err;

  int pass_cnt;
  int total_cnt;

  axi_rd_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_araddr0(s_araddr0), .s_araddr1(s_araddr1),
    .s_arlen0(s_arlen0), .s_arlen1(s_arlen1),
    .s_arburst0(s_arburst0), .s_arburst1(s_arburst1),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .s_rready(s_rready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arburst(m_arburst), .m_arid(m_arid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_rid(m_rid), .m_rresp(m_rresp), .m_rready(m_rready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] word(input int port, input int idx);
    return 64'hA5A5_0000_0000_0000 + (64'(port) << 32) + 64'(idx);
  endfunction

  // IDLE-cycle grant, AR hold for ar_hold cycles, then a silent gap of r_delay cycles
  task automatic grant(input int port, input logic [1:0] arv_after, input logic [31:0] addr,
                       input logic [3:0] len, input logic [1:0] burst, input int ar_hold,
                       input int r_delay);
    logic [1:0] exp_rdy;
    exp_rdy = (port == 1) ? 2'b10 : 2'b01;
    #1;
    chk("arready_grant", 64'(s_arready), 64'(exp_rdy));
    chk("busy_idle", 64'(busy), 64'(1'b0));
    tick();
    s_arvalid = arv_after;
    #1;
    chk("m_arvalid", 64'(m_arvalid), 64'(1'b1));
    chk("m_araddr", 64'(m_araddr), 64'(addr));
    chk("m_arlen", 64'(m_arlen), 64'(len));
    chk("m_arburst", 64'(m_arburst), 64'(burst));
    chk("m_arid", 64'(m_arid), 64'(port));
    chk("arready_in_ar", 64'(s_arready), 64'(2'b00));
    chk("busy_ar", 64'(busy), 64'(1'b1));
    for (int h = 0; h < ar_hold; h++) begin
      tick();
      chk("m_arvalid_held", 64'(m_arvalid), 64'(1'b1));
      chk("m_araddr_held", 64'(m_araddr), 64'(addr));
    end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    for (int d = 0; d < r_delay; d++) tick();
    chk("s_rvalid_quiet", 64'(s_rvalid), 64'(2'b00));
  endtask

  // Slave returns nbeats words; rlast on beat last_idx; optional ready toggling
  task automatic beats(input int port, input int nbeats, input int last_idx, input logic toggle);
    int   acc;
    int   guard;
    logic ph;
    logic [1:0] exp_v;
    acc   = 0;
    guard = 0;
    ph    = 1'b1;
    exp_v = (port == 1) ? 2'b10 : 2'b01;
    while (acc < nbeats && guard < 64) begin
      s_rready       = 2'b11;
      s_rready[port] = ph;
      m_rvalid       = 1'b1;
      m_rid          = 4'(port);
      m_rdata        = word(port, acc);
      m_rlast        = (acc == last_idx);
      #1;
      chk("s_rvalid_route", 64'(s_rvalid), 64'(exp_v));
      chk("m_rready_mirror", 64'(m_rready), 64'(ph));
      chk("s_rdata_order", s_rdata, word(port, acc));
      tick();
      if (ph) acc++;
      if (toggle) ph = ~ph;
      guard++;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s_rready = 2'b00;
    chk("beats_delivered", 64'(acc), 64'(nbeats));
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    rst_n      = 1'b0;
    s_arvalid  = 2'b00;
    s_araddr0  = 32'h0;
    s_araddr1  = 32'h0;
    s_arlen0   = 4'd0;
    s_arlen1   = 4'd0;
    s_arburst0 = 2'd1;
    s_arburst1 = 2'd1;
    s_rready   = 2'b00;
    m_arready  = 1'b0;
    m_rvalid   = 1'b0;
    m_rdata    = 64'h0;
    m_rlast    = 1'b0;
    m_rid      = 4'd0;
    m_rresp    = 2'd0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_err", 64'(err), 64'(1'b0));
    chk("rst_m_arvalid", 64'(m_arvalid), 64'(1'b0));
    chk("rst_m_araddr", 64'(m_araddr), 64'(32'h0));
    chk("rst_m_arid", 64'(m_arid), 64'(4'd0));
    chk("rst_s_arready", 64'(s_arready), 64'(2'b00));

    // Single port-0 request, AR held off 2 cycles, 50-cycle slave delay
    s_araddr0 = 32'h0000_0100; s_arlen0 = 4'd3; s_arburst0 = 2'd1;
    s_arvalid = 2'b01;
    grant(0, 2'b00, 32'h0000_0100, 4'd3, 2'd1, 2, 50);
    beats(0, 4, 3, 1'b0);
    chk("t1_busy_after", 64'(busy), 64'(1'b0));
    chk("t1_err", 64'(err), 64'(1'b0));

    // Simultaneous requests after reset: port 0 first, then port 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    s_araddr0 = 32'h200; s_arlen0 = 4'd7;
    s_araddr1 = 32'h400; s_arlen1 = 4'd7; s_arburst1 = 2'd2;
    s_arvalid = 2'b11;
    grant(0, 2'b10, 32'h200, 4'd7, 2'd1, 0, 1);
    beats(0, 8, 7, 1'b0);
    grant(1, 2'b00, 32'h400, 4'd7, 2'd2, 0, 1);
    beats(1, 8, 7, 1'b0);
    chk("sim_err", 64'(err), 64'(1'b0));

    // Fairness: both ports keep requesting single-beat bursts
    s_arlen0 = 4'd0; s_arlen1 = 4'd0; s_arburst1 = 2'd1;
    s_arvalid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      grant(k % 2, 2'b11, (k % 2 == 1) ? 32'h400 : 32'h200, 4'd0, 2'd1, 0, 0);
      beats(k % 2, 1, 0, 1'b0);
    end
    s_arvalid = 2'b00;
    chk("fair_err", 64'(err), 64'(1'b0));

    // Backpressure on port 1 with ready toggling every cycle
    s_araddr1 = 32'h800; s_arlen1 = 4'd7;
    s_arvalid = 2'b10;
    grant(1, 2'b00, 32'h800, 4'd7, 2'd1, 0, 2);
    beats(1, 8, 7, 1'b1);
    chk("bp_busy_after", 64'(busy), 64'(1'b0));
    chk("bp_err", 64'(err), 64'(1'b0));

    // Early rlast on beat 2 of a 4-beat burst
    s_araddr0 = 32'h0000_0100; s_arlen0 = 4'd3;
    s_arvalid = 2'b01;
    grant(0, 2'b00, 32'h0000_0100, 4'd3, 2'd1, 0, 0);
    beats(0, 2, 1, 1'b0);
    chk("short_err", 64'(err), 64'(1'b1));
    chk("short_idle", 64'(busy), 64'(1'b0));
    s_araddr1 = 32'h440; s_arlen1 = 4'd0;
    s_arvalid = 2'b10;
    grant(1, 2'b00, 32'h440, 4'd0, 2'd1, 0, 0);
    beats(1, 1, 0, 1'b0);
    chk("short_err_sticky", 64'(err), 64'(1'b1));

    // Reset during beat 2 abandons the burst and clears err
    s_araddr0 = 32'h0000_0300; s_arlen0 = 4'd3;
    s_arvalid = 2'b01;
    grant(0, 2'b00, 32'h0000_0300, 4'd3, 2'd1, 0, 0);
    beats(0, 1, 15, 1'b0);
    s_rready = 2'b01;
    m_rvalid = 1'b1;
    m_rid    = 4'd0;
    m_rdata  = word(0, 1);
    rst_n    = 1'b0;
    tick();
    m_rvalid = 1'b0;
    s_rready = 2'b00;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(1'b0));
    chk("mid_rst_err", 64'(err), 64'(1'b0));
    chk("mid_rst_m_arvalid", 64'(m_arvalid), 64'(1'b0));
    chk("mid_rst_m_araddr", 64'(m_araddr), 64'(32'h0));
    chk("mid_rst_s_rvalid", 64'(s_rvalid), 64'(2'b00));
    chk("mid_rst_m_rready", 64'(m_rready), 64'(1'b0));
    rst_n = 1'b1;
    s_araddr1 = 32'h0000_0900; s_arlen1 = 4'd1;
    s_arvalid = 2'b10;
    grant(1, 2'b00, 32'h0000_0900, 4'd1, 2'd1, 0, 0);
    beats(1, 2, 1, 1'b0);
    chk("fresh_err", 64'(err), 64'(1'b0));
    chk("fresh_busy", 64'(busy), 64'(1'b0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI read master port (AR + R channels, 64-bit data, 4-bit len) between two requesters: port 0 = I-cache refill, port 1 = D-cache refill.
- Sits between the cache controllers and the memory-side read slave.
- Round-robin grant, one outstanding burst at a time.
- Routes R beats back to the granted requester.
- Checks that the beat count matches the requested length.

Parameters:
- ADDR_WIDTH, 32, AR address width.
- DATA_WIDTH, 64, R data width.
- ID_WIDTH, 4, AXI ID width. Must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- s_arvalid  in  2  per-requester AR valid; bit i = requester i
- s_araddr0, s_araddr1  in  ADDR_WIDTH each  requester addresses
- s_arlen0, s_arlen1  in  4 each  burst length minus 1
- s_arburst0, s_arburst1  in  2 each  0=FIXED, 1=INCR, 2=WRAP
- s_arready  out  2  per-requester accept
- s_rvalid  out  2  per-requester R valid
- s_rdata  out  DATA_WIDTH  R data, broadcast to both requesters
- s_rlast  out  1  last beat, broadcast
- s_rready  in  2  per-requester R ready
- m_arvalid  out  1  master AR valid
- m_araddr  out  ADDR_WIDTH  master AR address
- m_arlen  out  4  master AR length
- m_arburst  out  2  master AR burst type
- m_arid  out  ID_WIDTH  master AR ID
- m_arready  in  1  master AR ready
- m_rvalid  in  1  master R valid
- m_rdata  in  DATA_WIDTH  master R data
- m_rlast  in  1  master R last
- m_rid  in  ID_WIDTH  master R ID
- m_rresp  in  2  master R response
- m_rready  out  1  master R ready
- busy  out  1  high when state != IDLE
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset: state=IDLE; last_grant=1 (port 0 wins the first tie); beat_cnt=0; err=0.
  - All valid/ready outputs 0; m_araddr/m_arlen/m_arburst/m_arid = 0.
- Reset mid-burst abandons the transaction immediately. The slave must be reset together with the arbiter.
- States: IDLE, AR, R.
- IDLE:
  - If any s_arvalid bit is set, grant g: the sole requester, or on a tie the port != last_grant.
  - Assert s_arready[g]=1 combinationally in the same cycle.
  - Latch addr/len/burst of g into the m_* registers; m_arid = g zero-extended.
  - Set last_grant=g, beat_cnt=0. Next state AR.
  - The loser's s_arready stays 0; its request stays pending.
- AR: m_arvalid=1 from registers, held stable until m_arready. On m_arready, next state R.
  - Minimum latency: s_arvalid at cycle N, m_arvalid at N+1.
- R (combinational pass-through to grant g only):
  - s_rvalid[g]=m_rvalid; s_rvalid[!g]=0; m_rready=s_rready[g].
  - On each m_rvalid&&m_rready: beat_cnt++ (5-bit counter).
  - Accepted beat with m_rlast=1: next state IDLE.
- No s_arready is asserted in AR or R, so a new grant cannot start before the previous burst's last beat has been accepted.
- The IDLE arrival cycle following a last beat may grant immediately (zero bubble beyond the IDLE cycle).
- err (sticky) is set on an accepted beat where any of these hold:
  - m_rlast=1 and beat_cnt != latched len;
  - m_rlast=0 and beat_cnt == latched len;
  - m_rid != latched ID;
  - m_rresp != 0.
- err does not alter routing; a burst still terminates only on m_rlast.
- err clears only on reset.
- m_rvalid outside state R is ignored (m_rready=0) and sets err.

Decomposition:
- Shared package axi_rd_pkg:
  - burst encodings FIXED/INCR/WRAP;
  - state enum {IDLE, AR, R};
  - a request struct {addr, len, burst}.
- One natural sub-module: rr_arb2, the two-way round-robin picker (inputs req[1:0], last_grant; output gnt one-hot).

Test Plan:
- Single request: port 0, araddr=0x0000_0100, arlen=3, INCR, slave AR-to-R delay 50 -> m_arid=0; 4 beats routed to s_rvalid[0] only; rlast on beat 4; err=0; busy low afterwards.
- Simultaneous requests after reset: both ports, addr0=0x200, addr1=0x400, len=7 each -> port 0 served first and fully, then port 1 with m_araddr=0x400 and m_arid=1; no interleaving.
- Fairness: both ports request continuously for 6 bursts -> grant order 0,1,0,1,0,1.
- Backpressure: s_rready[1] toggled every cycle during a port-1 len=7 burst -> m_rready mirrors it; exactly 8 beats delivered; data order preserved (check against preloaded words).
- Length mismatch: slave returns rlast on beat 2 for arlen=3 -> err=1 and stays 1; arbiter returns to IDLE and serves the next request.
- Reset mid-burst: assert rst_n=0 during beat 2 -> next cycle all outputs 0, state IDLE, err=0; a fresh request then completes normally.
